// File: rtl/square_seq.sv
// square_seq: sequential shift-add squarer, f_out = x_in^2 for a 17-bit signed argument (clk, async active-low reset, start/x_in in, busy/valid/f_out out, count_o/f_o/s_o test taps)
module square_seq (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [16:0] x_in,
  output logic               busy,
  output logic               valid,
  output logic signed [33:0] f_out,
  output logic        [4:0]  count_o,
  output logic signed [33:0] f_o,
  output logic        [1:0]  s_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, ABS = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;
  state_t      r_s;
  logic [16:0] r_x;
  logic [33:0] r_mcand;
  logic [16:0] r_mplier;
  logic [33:0] r_acc;
  logic [4:0]  r_count;
  logic        r_busy;
  logic        r_valid;
  logic [33:0] r_f;
  logic [16:0] w_mag;
  assign w_mag = r_x[16] ? ~r_x + 17'd1 : r_x;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_s      <= IDLE;
      r_x      <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_f      <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_s)
        IDLE: if (start) begin
          r_x    <= x_in;
          r_busy <= 1'b1;
          r_s    <= ABS;
        end
        ABS: begin
          r_mcand  <= {17'd0, w_mag};
          r_mplier <= w_mag;
          r_acc    <= '0;
          r_count  <= '0;
          r_s      <= MUL;
        end
        MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 5'd1;
          if (r_count == 5'd16) r_s <= DONE;
        end
        DONE: begin
          r_f     <= r_acc;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_s     <= IDLE;
        end
      endcase
    end
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign f_out   = r_f;
  assign count_o = r_count;
  assign f_o     = r_acc;
  assign s_o     = r_s;
endmodule
